reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 110 +++++++++++
 tb/tb_reg_file_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_param
// Description : Two-read / one-write register file with write-first bypass,
//               optional hardwired-zero register 0 and a sequential clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_wr_discard;
    logic              w_wr_ok;
    logic              w_r0_rd1;
    logic              w_r0_rd2;

    assign w_busy       = (r_state == CLEAR);
    assign w_wr_discard = (ZERO_R0 != 0) && (wr_addr == '0);
    // rst gates the bypass so reads show reset contents while reset is held
    assign w_wr_ok      = wr_en && !w_busy && !w_wr_discard && !rst;
    assign w_cnt_inc    = r_cnt + (ADDR_W+1)'(1);

    assign w_r0_rd1 = (ZERO_R0 != 0) && (rd_addr1 == '0);
    assign w_r0_rd2 = (ZERO_R0 != 0) && (rd_addr2 == '0);

    assign rd_data1 = w_r0_rd1                          ? '0      :
                      (w_wr_ok && (wr_addr == rd_addr1)) ? wr_data :
                                                           r_mem[rd_addr1];
    assign rd_data2 = w_r0_rd2                          ? '0      :
                      (w_wr_ok && (wr_addr == rd_addr2)) ? wr_data :
                                                           r_mem[rd_addr2];

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

    // Control: sweep FSM, counter with carry-out terminal detect, drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wr_en && w_busy;
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (w_cnt_inc[ADDR_W]) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage: reset loads each register with its own index (register 0 gets 0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (w_busy) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_param
// Description : Self-checking bench for reg_file_param against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic        wr_drop;

    int          n_checks;
    int          n_fail;
    int          busy_seen;
    string       phase;

    // Reference model: plain array plus a "sweep in progress" flag and position
    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_sweep;
    bit          m_drop;

    reg_file_param #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .ZERO_R0 (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s:%s got=%h exp=%h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!m_busy && wr_en && (wr_addr == a)) return wr_data;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'(i);
        m_busy  = 0;
        m_sweep = 0;
        m_drop  = 0;
    endtask

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic clr, input logic [4:0] a1, input logic [4:0] a2);
        #1;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        clr_req  = clr;
        rd_addr1 = a1;
        rd_addr2 = a2;
        @(negedge clk);
        check("rd1",     rd_data1,       exp_rd(a1));
        check("rd2",     rd_data2,       exp_rd(a2));
        check("busy",    32'(busy),      32'(m_busy));
        check("wr_drop", 32'(wr_drop),   32'(m_drop));
        if (busy) busy_seen++;
        @(posedge clk);
        if (m_busy) begin
            m_mem[m_sweep] = 32'd0;
            m_drop         = we;
            m_sweep++;
            if (m_sweep == 32) begin
                m_busy  = 0;
                m_sweep = 0;
            end
        end else begin
            m_drop = 0;
            if (we && (wa != 5'd0)) m_mem[wa] = wd;
            if (clr) begin
                m_busy  = 1;
                m_sweep = 0;
            end
        end
    endtask

    // Asserts reset off-edge, holds it across one edge with write/clear
    // requests active, then releases it away from the edge.
    task automatic do_reset();
        #1;
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = $urandom;
        clr_req  = 1'b1;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd0;
        model_reset();
        #1;
        check("rst_rd1",     rd_data1,     32'd5);
        check("rst_rd2",     rd_data2,     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_rd1",  rd_data1,  32'd5);
        check("rst_hold_busy", 32'(busy), 32'd0);
        #1;
        rst     = 1'b0;
        wr_en   = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        busy_seen = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_req   = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        model_reset();

        phase = "reset";
        do_reset();
        for (int i = 0; i < 32; i++) cycle(0, 5'd0, 32'd0, 0, 5'(i), 5'(31 - i));

        phase = "bypass";
        cycle(1, 5'd7, 32'hDEADBEEF, 0, 5'd7, 5'd7);
        cycle(0, 5'd0, 32'd0,        0, 5'd7, 5'd7);

        phase = "r0";
        cycle(1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0);
        cycle(0, 5'd0, 32'd0,        0, 5'd0, 5'd0);

        phase = "clear";
        busy_seen = 0;
        cycle(1, 5'd12, 32'hCAFEF00D, 1, 5'd12, 5'd31);
        for (int k = 0; k < 32; k++) cycle(k == 5, 5'd9, 32'hAA, k == 8, 5'd3, 5'd31);
        cycle(0, 5'd0, 32'd0, 0, 5'd9, 5'd12);
        check("busy_cycles", 32'(busy_seen), 32'd32);
        for (int i = 0; i < 32; i++) cycle(0, 5'd0, 32'd0, 0, 5'(i), 5'(31 - i));

        phase = "rst_mid";
        cycle(0, 5'd0, 32'd0, 1, 5'd3, 5'd31);
        for (int k = 0; k < 10; k++) cycle(0, 5'd0, 32'd0, 0, 5'd3, 5'd31);
        do_reset();
        for (int i = 0; i < 32; i++) cycle(0, 5'd0, 32'd0, 0, 5'(i), 5'(31 - i));
        cycle(1, 5'd20, 32'h0BADF00D, 0, 5'd20, 5'd19);
        cycle(0, 5'd0,  32'd0,        0, 5'd20, 5'd20);

        phase = "random";
        for (int n = 0; n < 500; n++) begin
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [31:0] wd;
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle($urandom_range(0, 1) == 1, wa, wd, $urandom_range(0, 39) == 0, a1, a2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
